// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states and
// the datapath select / error code values it drives.
package cpu_ctrl_pkg;

  localparam int unsigned OP_AND  = 0;
  localparam int unsigned OP_ADD  = 1;
  localparam int unsigned OP_SUB  = 2;
  localparam int unsigned OP_ANDI = 3;
  localparam int unsigned OP_ADDI = 4;
  localparam int unsigned OP_LW   = 5;
  localparam int unsigned OP_SW   = 6;
  localparam int unsigned OP_BEQ  = 7;
  localparam int unsigned OP_J    = 8;
  localparam int unsigned OP_JAL  = 9;
  localparam int unsigned OP_RET  = 10;
  localparam int unsigned OP_STOP = 11;

  typedef enum logic [2:0] {
    S_RST       = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_RETREG = 2'd3
  } pc_src_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_src_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2
  } alu_op_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_STOP    = 2'd1,
    ERR_ILLEGAL = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts wait cycles of one memory access; expire fires on the cycle the
// wait budget would be exhausted and the memory is still not ready.
module mem_timeout_counter #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic ready,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !ready && (count != W'(LIMIT))) begin
      count <= count + W'(1);
    end
  end

  // ready on the final allowed cycle wins over expiry
  assign expire = enable && !ready && (count == W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the multicycle datapath: fetch/decode/execute/memory/
// writeback with a memory req/ready handshake and timeout abort.
module multicycle_control_unit #(
  parameter int OPCODE_W    = 6,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                alu_src_b,
  output logic [1:0]          alu_op,
  output logic                reg_write,
  output logic [1:0]          wb_src,
  output logic                reg_dst,
  output logic                halted,
  output logic [1:0]          err_code,
  output logic [CNT_W-1:0]    retired
);

  import cpu_ctrl_pkg::*;

  state_t      state, state_next;
  logic [1:0]  err_next;
  logic [31:0] op;
  logic        retire_inc;
  logic        tmo_clear;
  logic        tmo_expire;

  assign op = 32'(opcode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RST;
      err_code <= ERR_NONE;
      retired  <= '0;
    end else begin
      state    <= state_next;
      err_code <= err_next;
      if (retire_inc) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_next = state;
    err_next   = err_code;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    alu_src_b  = 1'b0;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    wb_src     = WB_ALU;
    reg_dst    = 1'b0;
    halted     = 1'b0;

    case (state)
      S_RST: state_next = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          pc_src     = PC_PLUS4;
          state_next = S_DECODE;
        end else if (tmo_expire) begin
          state_next = S_HALT;
          err_next   = ERR_TIMEOUT;
        end
      end

      S_DECODE: begin
        if (op == OP_J) begin
          pc_write   = 1'b1;
          pc_src     = PC_JUMP;
          state_next = S_FETCH;
        end else if (op == OP_JAL) begin
          pc_write   = 1'b1;
          pc_src     = PC_JUMP;
          reg_write  = 1'b1;
          wb_src     = WB_PC4;
          reg_dst    = 1'b1;
          state_next = S_FETCH;
        end else if (op == OP_RET) begin
          pc_write   = 1'b1;
          pc_src     = PC_RETREG;
          state_next = S_FETCH;
        end else if (op == OP_STOP) begin
          state_next = S_HALT;
          err_next   = ERR_STOP;
        end else if (op > OP_STOP) begin
          state_next = S_HALT;
          err_next   = ERR_ILLEGAL;
        end else begin
          state_next = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        alu_src_b = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_LW) || (op == OP_SW);
        if ((op == OP_SUB) || (op == OP_BEQ))       alu_op = ALU_SUB;
        else if ((op == OP_AND) || (op == OP_ANDI)) alu_op = ALU_AND;
        if (op == OP_BEQ) begin
          pc_write   = alu_zero;
          pc_src     = PC_BRANCH;
          state_next = S_FETCH;
        end else if ((op == OP_LW) || (op == OP_SW)) begin
          state_next = S_MEMORY;
        end else begin
          state_next = S_WRITEBACK;
        end
      end

      S_MEMORY: begin
        mem_req = 1'b1;
        mem_we  = (op == OP_SW);
        if (mem_ready) begin
          state_next = (op == OP_SW) ? S_FETCH : S_WRITEBACK;
        end else if (tmo_expire) begin
          state_next = S_HALT;
          err_next   = ERR_TIMEOUT;
        end
      end

      S_WRITEBACK: begin
        reg_write  = 1'b1;
        wb_src     = (op == OP_LW) ? WB_MEM : WB_ALU;
        reg_dst    = 1'b0;
        state_next = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: state_next = S_RST;
    endcase
  end

  // only instruction completions count, not the start-up RST->FETCH step
  assign retire_inc = (state_next == S_FETCH) &&
                      ((state == S_DECODE) || (state == S_EXECUTE) ||
                       (state == S_MEMORY) || (state == S_WRITEBACK));

  assign tmo_clear = (state_next != state) &&
                     ((state_next == S_FETCH) || (state_next == S_MEMORY));

  mem_timeout_counter #(
    .LIMIT (MEM_TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmo_clear),
    .enable (mem_req),
    .ready  (mem_ready),
    .expire (tmo_expire)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed scenarios plus a
// randomized instruction stream checked against an instruction-level model.
module tb_multicycle_control_unit;
  import cpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        alu_zero;
  logic        mem_ready;
  logic        mem_req, mem_we, ir_write, pc_write, alu_src_b, reg_write, reg_dst, halted;
  logic [1:0]  pc_src, alu_op, wb_src, err_code;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;
  int exp_retired = 0;

  multicycle_control_unit #(.OPCODE_W(6), .MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .wb_src(wb_src), .reg_dst(reg_dst), .halted(halted),
    .err_code(err_code), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] outs();
    return {mem_req, mem_we, ir_write, pc_write, pc_src, alu_src_b, alu_op,
            reg_write, wb_src, reg_dst, halted, err_code};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0; opcode = 6'(OP_ADD);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_retired = 0;
  endtask

  // Runs one non-halting instruction from its FETCH cycle; fw/mw are the
  // wait cycles the memory inserts before ready in fetch and memory access.
  task automatic run_instr(input int op, input logic z, input int fw, input int mw);
    int total, acc, wcnt, tgt;
    int n_req, n_we, n_ir, n_pcw, pcw_src, n_rw, rw_cyc, rw_wb, rw_dst, o_alu, o_b;
    int e_req, e_we, e_pcw, e_pcsrc, e_rw, e_rwcyc, e_wb, e_dst, e_alu, e_b;
    bit isjmp, ismem, isalu;
    opcode = 6'(op); alu_zero = z;
    isjmp = (op == OP_J) || (op == OP_JAL) || (op == OP_RET);
    ismem = (op == OP_LW) || (op == OP_SW);
    isalu = (op <= OP_ADDI);
    total = (isjmp ? 2 : (op == OP_BEQ) ? 3 : (op == OP_LW) ? 5 : 4) + fw + (ismem ? mw : 0);
    e_req   = fw + 1 + (ismem ? mw + 1 : 0);
    e_we    = (op == OP_SW) ? mw + 1 : 0;
    e_pcw   = 1 + (isjmp ? 1 : 0) + ((op == OP_BEQ && z) ? 1 : 0);
    e_pcsrc = (op == OP_J || op == OP_JAL) ? 2 : (op == OP_RET) ? 3 : (op == OP_BEQ && z) ? 1 : 0;
    e_rw    = (isalu || op == OP_LW || op == OP_JAL) ? 1 : 0;
    e_rwcyc = (op == OP_JAL) ? fw + 1 : (e_rw != 0) ? total - 1 : -1;
    e_wb    = (op == OP_JAL) ? 2 : (op == OP_LW) ? 1 : 0;
    e_dst   = (op == OP_JAL) ? 1 : 0;
    e_b     = (op == OP_ADDI || op == OP_ANDI || ismem) ? 1 : 0;
    e_alu   = (op == OP_SUB || op == OP_BEQ) ? 1 : (op == OP_AND || op == OP_ANDI) ? 2 : 0;
    acc = 0; wcnt = 0; n_req = 0; n_we = 0; n_ir = 0; n_pcw = 0; pcw_src = 0;
    n_rw = 0; rw_cyc = -1; rw_wb = 0; rw_dst = 0; o_alu = 0; o_b = 0;
    for (int c = 0; c < total; c++) begin
      @(negedge clk); #1;
      if (mem_req) begin
        tgt = (acc == 0) ? fw : mw;
        if (wcnt == tgt) begin mem_ready = 1'b1; acc++; wcnt = 0; end
        else begin mem_ready = 1'b0; wcnt++; end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      n_req += int'(mem_req); n_we += int'(mem_we); n_ir += int'(ir_write);
      if (pc_write) begin n_pcw++; if (!ir_write) pcw_src = int'(pc_src); end
      if (reg_write) begin
        if (n_rw == 0) begin rw_cyc = c; rw_wb = int'(wb_src); rw_dst = int'(reg_dst); end
        n_rw++;
      end
      o_alu |= int'(alu_op); o_b |= int'(alu_src_b);
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    exp_retired++;
    checks++; if (n_req !== e_req) begin errors++; $display("FAIL op%0d mem_req_cycles got %0d want %0d", op, n_req, e_req); end
    checks++; if (n_we !== e_we) begin errors++; $display("FAIL op%0d mem_we_cycles got %0d want %0d", op, n_we, e_we); end
    checks++; if (n_ir !== 1) begin errors++; $display("FAIL op%0d ir_write_cycles got %0d want 1", op, n_ir); end
    checks++; if (n_pcw !== e_pcw || pcw_src !== e_pcsrc) begin errors++;
      $display("FAIL op%0d pc_write got %0d/src%0d want %0d/src%0d", op, n_pcw, pcw_src, e_pcw, e_pcsrc); end
    checks++; if (n_rw !== e_rw || rw_cyc !== e_rwcyc) begin errors++;
      $display("FAIL op%0d reg_write got %0d@%0d want %0d@%0d", op, n_rw, rw_cyc, e_rw, e_rwcyc); end
    if (e_rw != 0) begin
      checks++; if (rw_wb !== e_wb || rw_dst !== e_dst) begin errors++;
        $display("FAIL op%0d wb_src/reg_dst got %0d/%0d want %0d/%0d", op, rw_wb, rw_dst, e_wb, e_dst); end
    end
    checks++; if (o_alu !== e_alu || o_b !== e_b) begin errors++;
      $display("FAIL op%0d alu_op/alu_src_b got %0d/%0d want %0d/%0d", op, o_alu, o_b, e_alu, e_b); end
    checks++; if (mem_req !== 1'b1 || halted !== 1'b0 || retired !== 32'(exp_retired)) begin errors++;
      $display("FAIL op%0d next_fetch got req%0b halt%0b ret%0d want req1 halt0 ret%0d", op, mem_req, halted, retired, exp_retired); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; alu_zero = 1'b1; opcode = 6'(OP_JAL);
    #1;
    checks++; if (outs() !== 16'h0 || retired !== 32'd0) begin errors++;
      $display("FAIL reset_outputs got %h ret %0d want 0000 ret 0", outs(), retired); end
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0; #1;
    checks++; if (outs() !== 16'h0) begin errors++; $display("FAIL rst_state_outputs got %h want 0000", outs()); end
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b1 || ir_write !== 1'b0) begin errors++;
      $display("FAIL rst_to_fetch got req%0b ir%0b want req1 ir0", mem_req, ir_write); end
    do_reset();
  endtask

  task automatic test_directed();
    do_reset();
    run_instr(OP_ADD, 1'b0, 0, 0);
    run_instr(OP_LW, 1'b0, 0, 3);
    run_instr(OP_BEQ, 1'b1, 0, 0);
    run_instr(OP_BEQ, 1'b0, 0, 0);
    run_instr(OP_JAL, 1'b0, 0, 0);
    run_instr(OP_SW, 1'b0, 2, 1);
    run_instr(OP_RET, 1'b0, 1, 0);
  endtask

  task automatic test_back_to_back();
    int op;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 10));
      run_instr(op, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
    end
  endtask

  task automatic test_halt(input int op, input logic [1:0] e_err);
    do_reset();
    run_instr(OP_ADD, 1'b0, 0, 0);
    opcode = 6'(op);
    @(negedge clk); mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (halted !== 1'b1 || err_code !== e_err || retired !== 32'(exp_retired)) begin errors++;
      $display("FAIL halt_op%0d got halt%0b err%0d ret%0d want halt1 err%0d ret%0d", op, halted, err_code, retired, e_err, exp_retired); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1)); alu_zero = 1'($urandom_range(0, 1));
      opcode = 6'($urandom_range(0, 63));
      #1;
      checks++; if (outs() !== {13'h0, 1'b1, e_err} || retired !== 32'(exp_retired)) begin errors++;
        $display("FAIL halt_frozen cyc%0d got %h ret%0d want %h ret%0d", i, outs(), retired, {13'h0, 1'b1, e_err}, exp_retired); end
    end
  endtask

  task automatic test_timeout();
    int n;
    bit done;
    do_reset();
    n = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk); mem_ready = 1'b0; #1;
      if (halted) done = 1;
      else if (mem_req) n++;
    end
    checks++; if (!done || n !== 15 || err_code !== 2'd3) begin errors++;
      $display("FAIL fetch_timeout got halt%0b waits%0d err%0d want halt1 waits15 err3", done, n, err_code); end
    do_reset();
    opcode = 6'(OP_ADD);
    repeat (14) begin @(negedge clk); mem_ready = 1'b0; end
    @(negedge clk); mem_ready = 1'b1; #1;
    checks++; if (ir_write !== 1'b1 || halted !== 1'b0) begin errors++;
      $display("FAIL ready_at_limit got ir%0b halt%0b want ir1 halt0", ir_write, halted); end
    @(posedge clk); #1; mem_ready = 1'b0;
    checks++; if (halted !== 1'b0 || mem_req !== 1'b0 || err_code !== 2'd0) begin errors++;
      $display("FAIL limit_to_decode got halt%0b req%0b err%0d want 0 0 0", halted, mem_req, err_code); end
    repeat (3) @(posedge clk); #1;
    checks++; if (retired !== 32'd1 || mem_req !== 1'b1) begin errors++;
      $display("FAIL limit_retire got ret%0d req%0b want ret1 req1", retired, mem_req); end
  endtask

  task automatic test_reset_mid_memory();
    do_reset();
    run_instr(OP_ADDI, 1'b0, 0, 0);
    opcode = 6'(OP_LW);
    @(negedge clk); mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin errors++;
      $display("FAIL lw_in_memory got req%0b we%0b want req1 we0", mem_req, mem_we); end
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    checks++; if (outs() !== 16'h0 || retired !== 32'd0) begin errors++;
      $display("FAIL mid_reset got %h ret%0d want 0000 ret0", outs(), retired); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL post_release got req%0b want 0", mem_req); end
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b1 || retired !== 32'd0) begin errors++;
      $display("FAIL resume_fetch got req%0b ret%0d want req1 ret0", mem_req, retired); end
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0; opcode = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_halt(63, 2'd2);
    test_halt(OP_STOP, 2'd1);
    test_timeout();
    test_reset_mid_memory();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore FSM that sequences the multicycle RISC datapath one instruction at a time: fetch, decode, execute, memory, writeback.
- Drives every datapath mux selection line (PC source, ALU B source, writeback source, register destination) and every register/memory enable.
- Runs a req/ready handshake with the shared instruction/data memory and aborts on a memory timeout.
- Sits between the IR opcode field and the datapath; holds no datapath values itself.

Parameters:
- OPCODE_W, 6, opcode field width.
- MEM_TIMEOUT, 15, maximum wait cycles for mem_ready per access (>=1).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  OPCODE_W  IR opcode field; stable from DECODE onward.
- alu_zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe, qualified by mem_req.
- ir_write  out  1  IR load enable.
- pc_write  out  1  PC load enable.
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = return register.
- alu_src_b  out  1  0 = register, 1 = immediate.
- alu_op  out  2  0 = ADD, 1 = SUB, 2 = AND.
- reg_write  out  1  register file write enable.
- wb_src  out  2  0 = ALU, 1 = memory data, 2 = PC+4.
- reg_dst  out  1  0 = rd field, 1 = R31.
- halted  out  1  FSM is in HALT.
- err_code  out  2  0 = none, 1 = STOP executed, 2 = illegal opcode, 3 = memory timeout.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
Reset and output rules
- Reset (asynchronous, active-low) forces state RST, timeout counter 0, retired 0, err_code 0.
- In RST all outputs are 0.
- All outputs decode combinationally from state and opcode, glitch-free with respect to registered state.
- Any output not listed for a state is 0.

States and transitions
- RST: always goes to FETCH on the next edge.
- FETCH: mem_req=1, mem_we=0.
  - While mem_ready=0: stay.
  - On mem_ready=1 in the same cycle: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE:
  - J: pc_write=1, pc_src=2; go to FETCH.
  - JAL: pc_write=1, pc_src=2, reg_write=1, wb_src=2, reg_dst=1; go to FETCH.
  - RET: pc_write=1, pc_src=3; go to FETCH.
  - STOP: go to HALT with err_code=1.
  - Undefined opcode: go to HALT with err_code=2.
  - All other opcodes: go to EXECUTE.
- EXECUTE:
  - alu_src_b=1 for ADDI, ANDI, LW, SW; 0 otherwise.
  - alu_op: SUB for SUB and BEQ; AND for AND and ANDI; ADD otherwise.
  - BEQ: pc_write = alu_zero, pc_src=1; go to FETCH.
  - LW and SW: go to MEMORY.
  - ALU opcodes: go to WRITEBACK.
- MEMORY: mem_req=1; mem_we=1 for SW.
  - While mem_ready=0: stay.
  - On mem_ready=1: LW goes to WRITEBACK, SW goes to FETCH.
- WRITEBACK: reg_write=1.
  - wb_src=1 for LW, 0 otherwise.
  - reg_dst=0.
  - Go to FETCH.
- HALT: halted=1; stay until reset; err_code holds its value.

Timeout
- Counter clears on entry to FETCH or MEMORY.
- Counter increments each cycle that mem_req=1 and mem_ready=0.
- When the count reaches MEM_TIMEOUT with mem_ready still 0: go to HALT with err_code=3.
- mem_ready=1 on the cycle the limit is hit has priority: the access completes.

Retired counter
- Increments by 1 on every transition into FETCH from DECODE, EXECUTE, MEMORY or WRITEBACK.
- Wraps modulo 2^CNT_W.
- Does not increment for the RST to FETCH transition or for HALT entry.

Latency (ready=1 immediately)
- J, JAL, RET: 2 cycles.
- BEQ: 3 cycles.
- ALU and SW: 4 cycles.
- LW: 5 cycles.

Other rules
- mem_ready outside FETCH or MEMORY is ignored.
- Reset asserted mid-access drops mem_req asynchronously.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - opcode constants: AND=0, ADD=1, SUB=2, ANDI=3, ADDI=4, LW=5, SW=6, BEQ=7, J=8, JAL=9, RET=10, STOP=11;
  - state encoding;
  - pc_src, wb_src, alu_op and err_code encodings.
- One sub-module is natural: mem_timeout_counter (clear, enable, expire flag).

Test Plan:
- ADD, mem_ready tied to 1: states FETCH, DECODE, EXECUTE, WRITEBACK.
  - Required: reg_write=1 only in cycle 4 with wb_src=0; retired goes 0 to 1.
- LW with mem_ready delayed 3 cycles in MEMORY: mem_req held for 4 cycles.
  - Required: WRITEBACK with wb_src=1; total 8 cycles.
- BEQ with alu_zero=1, then BEQ with alu_zero=0.
  - Required: first gives pc_write=1 and pc_src=1 in EXECUTE; second gives pc_write=0.
- JAL.
  - Required: in DECODE, pc_src=2, reg_write=1, wb_src=2, reg_dst=1; next state FETCH.
- Opcode 63, then STOP on a separate run.
  - Required: opcode 63 gives halted=1 and err_code=2; STOP gives err_code=1; retired unchanged; outputs stay frozen 20 cycles.
- mem_ready held 0 in FETCH.
  - Required: HALT after exactly 15 wait cycles with err_code=3.
  - Required: ready=1 on the 15th cycle completes the fetch instead.
- Reset pulse mid-MEMORY.
  - Required: mem_req=0 immediately; retired=0; FETCH resumes 2 edges after release.
